uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART path. Sits directly downstream of the baud-rate tick generator (mod_m_counter), whose oTICK drives iS_TICK.
- iS_TICK runs at 16x the bit rate. The block oversamples the serial line, recovers 8N1-style frames LSB-first, and presents each received word with a one-cycle completion strobe and a framing-error flag.

Parameters:
- DBIT, 8: data bits per frame; legal range 5..9.
- SB_TICK, 16: sampling ticks spent in the stop state; 16/24/32 give 1/1.5/2 stop bits.
- NW, $clog2(DBIT): width of the internal data-bit counter; derived, do not override.

Ports:
- iCLK  input  1  system clock; all state changes on rising edge.
- iRESET  input  1  asynchronous, active-high reset.
- iRX  input  1  raw serial line; idles high; asynchronous to iCLK.
- iS_TICK  input  1  16x oversampling enable, one iCLK cycle wide.
- oDOUT  output  DBIT  last completed received word.
- oRX_DONE_TICK  output  1  one-cycle pulse: a frame has finished and oDOUT is valid.
- oFRAME_ERR  output  1  stop bit of the last completed frame sampled low.

Behaviour:
- Reset: async, active-high, forces the following.
  - state=IDLE; s=0; n=0; shift register=0.
  - Synchronizer flops=1.
  - oDOUT=0, oRX_DONE_TICK=0, oFRAME_ERR=0.
- Input sync: iRX passes through a 2-flop synchronizer giving rx_s; 2 iCLK of latency. All decisions use rx_s only.
- Counters:
  - s: 5-bit tick counter, wide enough for SB_TICK-1=31.
  - n: NW-bit data-bit counter.
  - Both advance only on cycles with iS_TICK=1. With iS_TICK=0, every register holds except the IDLE start-detect.
- IDLE:
  - rx_s==0 (sampled every iCLK, tick not required) -> START, s=0.
- START:
  - On tick with s==7 and rx_s==0 -> DATA, s=0, n=0.
  - On tick with s==7 and rx_s==1 -> IDLE. This rejects a glitch; no strobe, no output change.
  - On any other tick -> s++.
- DATA:
  - On tick with s==15: s=0, shift={rx_s, shift[DBIT-1:1]}, i.e. LSB received first.
    - If n==DBIT-1 -> STOP; otherwise n++.
  - On any other tick -> s++.
- STOP:
  - On tick with s==15: capture stop_bad = ~rx_s. This is the mid-point of the first stop bit.
  - On tick with s==SB_TICK-1 -> IDLE, s=0. Then at that same edge:
    - oDOUT <= shift.
    - oFRAME_ERR <= stop_bad. For SB_TICK==16 the two events coincide; use the current rx_s.
    - oRX_DONE_TICK <= 1 for exactly one iCLK cycle.
  - On any other tick -> s++.
- Output timing:
  - oDOUT and oFRAME_ERR are registered and change only at frame completion. They hold until the next completion.
  - oRX_DONE_TICK is registered and cleared the following cycle.
  - A frame with a bad stop bit still produces the strobe and the data, with oFRAME_ERR=1.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after completion.
- Line held low (break): the block completes a frame of zeros with oFRAME_ERR=1. It then re-enters START on every subsequent IDLE cycle; there is no lockup.
- Reset mid-frame: the frame is abandoned, no strobe is issued, and outputs return to their reset values.
- Encoding: the state register is 2 bits (IDLE=0, START=1, DATA=2, STOP=3). Unreachable values are impossible with 2 bits, but the default branch returns to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams IDLE/START/DATA/STOP;
  - OVERSAMPLE=16 and MID_TICK=7;
  - default DBIT/SB_TICK values, shared with the future uart_tx.
- One sub-module: sync_2ff (generic 2-flop synchronizer with a reset value parameter, reset value 1 here). It is reused for all asynchronous inputs.

Test Plan:
- Tick = mod_m_counter SIZE=4 (one tick every 4 clocks; bit = 64 clocks). Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1). Required:
  - oDOUT=0xA5, oFRAME_ERR=0.
  - oRX_DONE_TICK high for exactly 1 cycle, ~9.5 bit periods after the start edge plus 2 sync cycles.
  - No other strobes.
- Glitch rejection: drive iRX low for 20 clocks (5 ticks), then high. Required: FSM returns to IDLE, no strobe, oDOUT unchanged.
- Framing error: send 0x3C with the stop bit driven 0. Required: strobe once, oDOUT=0x3C, oFRAME_ERR=1. A following good 0x55 frame gives oFRAME_ERR=0.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap. Required: three strobes, oDOUT sequence 0x00, 0xFF, 0x81, no errors.
- Reset mid-frame: assert iRESET during data bit 3 of 0xC3, then send 0x5A. Required:
  - On reset, all outputs go 0 asynchronously.
  - There is no strobe for the aborted frame.
  - The next strobe carries 0x5A.
- Parameter sweep: DBIT=7, SB_TICK=32; send 0x2B. Required: oDOUT=0x2B, strobe 2 bit periods after the last data-bit sample.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, oversampling constants and frame defaults shared by the UART blocks
package uart_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK = 7;
   localparam int DEF_DBIT = 8;
   localparam int DEF_SB_TICK = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs
// iCLK/iRESET: destination clock, async active-high reset (flops load RST_VAL)
// iD: asynchronous input; oQ: synchronized output, two iCLK of latency
module sync_2ff #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         iCLK,
   input  logic         iRESET,
   input  logic [W-1:0] iD,
   output logic [W-1:0] oQ
);
   logic [W-1:0] meta;
   always_ff @(posedge iCLK or posedge iRESET)
      if (iRESET) begin
         meta <= RST_VAL;
         oQ   <= RST_VAL;
      end else begin
         meta <= iD;
         oQ   <= meta;
      end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB-first frames with framing-error flag
// iCLK/iRESET: clock, async active-high reset
// iRX: raw serial line (idles high); iS_TICK: 16x bit-rate enable
// oDOUT: last completed word; oRX_DONE_TICK: one-cycle completion strobe
// oFRAME_ERR: stop bit of the last completed frame was sampled low
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK,
   parameter int NW = $clog2(DBIT)
) (
   input  logic            iCLK,
   input  logic            iRESET,
   input  logic            iRX,
   input  logic            iS_TICK,
   output logic [DBIT-1:0] oDOUT,
   output logic            oRX_DONE_TICK,
   output logic            oFRAME_ERR
);
   logic            rx_s;
   logic [1:0]      state_r, state_n;
   logic [4:0]      s_r, s_n;
   logic [NW-1:0]   n_r, n_n;
   logic [DBIT-1:0] b_r, b_n, dout_n;
   logic            bad_r, bad_n, done_n, ferr_n;

   sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (
      .iCLK  (iCLK),
      .iRESET(iRESET),
      .iD    (iRX),
      .oQ    (rx_s)
   );

   always_comb begin
      state_n = state_r;
      s_n     = s_r;
      n_n     = n_r;
      b_n     = b_r;
      bad_n   = bad_r;
      dout_n  = oDOUT;
      ferr_n  = oFRAME_ERR;
      done_n  = 1'b0;
      case (state_r)
         IDLE:
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         START:
            if (iS_TICK) begin
               if (s_r == 5'(MID_TICK)) begin
                  state_n = rx_s ? IDLE : DATA;
                  s_n     = '0;
                  n_n     = '0;
               end else
                  s_n = s_r + 5'd1;
            end
         DATA:
            if (iS_TICK) begin
               if (s_r == 5'(OVERSAMPLE - 1)) begin
                  s_n = '0;
                  b_n = {rx_s, b_r[DBIT-1:1]};
                  if (n_r == NW'(DBIT - 1))
                     state_n = STOP;
                  else
                     n_n = n_r + 1'b1;
               end else
                  s_n = s_r + 5'd1;
            end
         STOP:
            if (iS_TICK) begin
               if (s_r == 5'(OVERSAMPLE - 1))
                  bad_n = ~rx_s;
               if (s_r == 5'(SB_TICK - 1)) begin
                  state_n = IDLE;
                  s_n     = '0;
                  dout_n  = b_r;
                  // with a single stop bit the mid-stop sample and completion share one tick
                  ferr_n  = (SB_TICK == OVERSAMPLE) ? ~rx_s : bad_r;
                  done_n  = 1'b1;
               end else
                  s_n = s_r + 5'd1;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET)
      if (iRESET) begin
         state_r       <= IDLE;
         s_r           <= '0;
         n_r           <= '0;
         b_r           <= '0;
         bad_r         <= 1'b0;
         oDOUT         <= '0;
         oFRAME_ERR    <= 1'b0;
         oRX_DONE_TICK <= 1'b0;
      end else begin
         state_r       <= state_n;
         s_r           <= s_n;
         n_r           <= n_n;
         b_r           <= b_n;
         bad_r         <= bad_n;
         oDOUT         <= dout_n;
         oFRAME_ERR    <= ferr_n;
         oRX_DONE_TICK <= done_n;
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a 4-clock tick (64 clocks per bit)
module tb_uart_rx;
   logic       iCLK = 1'b0;
   logic       iRESET = 1'b1;
   logic       rx = 1'b1, rx7 = 1'b1;
   logic [1:0] tcnt;
   logic       tick;
   logic [7:0] dout;
   logic [6:0] dout7;
   logic       done, ferr, done7, ferr7;
   int         cyc = 0, dcnt = 0, dcnt7 = 0, last_cyc = 0, last_cyc7 = 0;
   int         passed = 0, total = 0, start_cyc = 0, lat = 0;
   logic [7:0] q[$];

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK or posedge iRESET)
      if (iRESET) tcnt <= '0;
      else tcnt <= tcnt + 2'd1;
   assign tick = (tcnt == 2'd3);

   always @(posedge iCLK) cyc <= cyc + 1;

   uart_rx dut (
      .iCLK(iCLK), .iRESET(iRESET), .iRX(rx), .iS_TICK(tick),
      .oDOUT(dout), .oRX_DONE_TICK(done), .oFRAME_ERR(ferr)
   );

   uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
      .iCLK(iCLK), .iRESET(iRESET), .iRX(rx7), .iS_TICK(tick),
      .oDOUT(dout7), .oRX_DONE_TICK(done7), .oFRAME_ERR(ferr7)
   );

   always @(negedge iCLK) begin
      if (done) begin
         dcnt++;
         last_cyc = cyc;
         q.push_back(dout);
      end
      if (done7) begin
         dcnt7++;
         last_cyc7 = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drv(input bit w, input logic v, input int n);
      if (w) rx7 = v;
      else rx = v;
      repeat (n) @(negedge iCLK);
   endtask

   task automatic send(input bit w, input logic [8:0] d, input int nb, input logic sv, input int sclk);
      drv(w, 1'b0, 64);
      for (int i = 0; i < nb; i++) drv(w, d[i], 64);
      drv(w, sv, sclk);
   endtask

   initial begin
      repeat (3) @(negedge iCLK);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_ferr", 32'(ferr), 32'h0);
      chk("rst_dout7", 32'(dout7), 32'h0);
      iRESET = 1'b0;
      drv(0, 1'b1, 20);

      start_cyc = cyc;
      send(0, 9'h0A5, 8, 1'b1, 64);
      drv(0, 1'b1, 64);
      lat = last_cyc - start_cyc;
      chk("a5_count", 32'(dcnt), 32'd1);
      chk("a5_dout", 32'(dout), 32'hA5);
      chk("a5_ferr", 32'(ferr), 32'h0);
      chk("a5_latency", 32'(lat >= 600 && lat <= 620), 32'h1);

      drv(0, 1'b0, 20);
      drv(0, 1'b1, 200);
      chk("glitch_count", 32'(dcnt), 32'd1);
      chk("glitch_dout", 32'(dout), 32'hA5);

      send(0, 9'h03C, 8, 1'b0, 48);
      drv(0, 1'b1, 200);
      chk("ferr_count", 32'(dcnt), 32'd2);
      chk("ferr_dout", 32'(dout), 32'h3C);
      chk("ferr_flag", 32'(ferr), 32'h1);
      send(0, 9'h055, 8, 1'b1, 64);
      drv(0, 1'b1, 64);
      chk("good_count", 32'(dcnt), 32'd3);
      chk("good_dout", 32'(dout), 32'h55);
      chk("good_ferr", 32'(ferr), 32'h0);

      q.delete();
      send(0, 9'h000, 8, 1'b1, 64);
      send(0, 9'h0FF, 8, 1'b1, 64);
      send(0, 9'h081, 8, 1'b1, 64);
      drv(0, 1'b1, 100);
      chk("b2b_count", 32'(dcnt), 32'd6);
      chk("b2b_w0", (q.size() > 0) ? 32'(q[0]) : 32'hDEAD, 32'h00);
      chk("b2b_w1", (q.size() > 1) ? 32'(q[1]) : 32'hDEAD, 32'hFF);
      chk("b2b_w2", (q.size() > 2) ? 32'(q[2]) : 32'hDEAD, 32'h81);
      chk("b2b_ferr", 32'(ferr), 32'h0);

      drv(0, 1'b0, 64);
      drv(0, 1'b1, 64);
      drv(0, 1'b1, 64);
      drv(0, 1'b0, 64);
      drv(0, 1'b0, 32);
      #3 iRESET = 1'b1;
      #1;
      chk("arst_dout", 32'(dout), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_ferr", 32'(ferr), 32'h0);
      rx = 1'b1;
      repeat (4) @(negedge iCLK);
      iRESET = 1'b0;
      drv(0, 1'b1, 100);
      chk("abort_count", 32'(dcnt), 32'd6);
      send(0, 9'h05A, 8, 1'b1, 64);
      drv(0, 1'b1, 64);
      chk("after_rst_count", 32'(dcnt), 32'd7);
      chk("after_rst_dout", 32'(dout), 32'h5A);

      drv(0, 1'b0, 700);
      chk("break_count", 32'(dcnt), 32'd8);
      chk("break_dout", 32'(dout), 32'h00);
      chk("break_ferr", 32'(ferr), 32'h1);
      drv(0, 1'b1, 800);

      start_cyc = cyc;
      send(1, 9'h02B, 7, 1'b1, 128);
      drv(1, 1'b1, 64);
      lat = last_cyc7 - start_cyc;
      chk("p7_count", 32'(dcnt7), 32'd1);
      chk("p7_dout", 32'(dout7), 32'h2B);
      chk("p7_ferr", 32'(ferr7), 32'h0);
      chk("p7_latency", 32'(lat >= 600 && lat <= 620), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
